// File: rtl/pll_profile_pkg.sv
// Shared definitions for the PLL profile sequencer: management register map,
// table entry record, the two stored counter profiles and the FSM state type.
package pll_profile_pkg;

   localparam int unsigned PROFILE_LEN = 7;
   localparam int unsigned IDX_W       = $clog2(PROFILE_LEN + 1);

   localparam logic [5:0] ADDR_MODE  = 6'h00;
   localparam logic [5:0] ADDR_START = 6'h02;
   localparam logic [5:0] ADDR_N     = 6'h03;
   localparam logic [5:0] ADDR_M     = 6'h04;
   localparam logic [5:0] ADDR_C     = 6'h05;
   localparam logic [5:0] ADDR_K     = 6'h07;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } entry_t;

   typedef entry_t profile_t [PROFILE_LEN];

   // Order: N, M, K, C0..C3; C words carry the counter select in [22:18]
   localparam profile_t PROFILE_A = '{
      '{ADDR_N, 32'h0001_0000},
      '{ADDR_M, 32'h0002_0504},
      '{ADDR_K, 32'h3333_32DD},
      '{ADDR_C, 32'h0000_0202},
      '{ADDR_C, 32'h0004_0202},
      '{ADDR_C, 32'h0008_0404},
      '{ADDR_C, 32'h000C_0808}
   };

   localparam profile_t PROFILE_B = '{
      '{ADDR_N, 32'h0000_0303},
      '{ADDR_M, 32'h0000_1B1B},
      '{ADDR_K, 32'h1D89_D89E},
      '{ADDR_C, 32'h0002_0504},
      '{ADDR_C, 32'h0006_0504},
      '{ADDR_C, 32'h0008_0A0A},
      '{ADDR_C, 32'h000E_1515}
   };

   typedef enum logic [2:0] {
      IDLE,
      WR_MODE,
      WR_TABLE,
      WR_START,
      WAIT_DROP,
      WAIT_LOCK,
      FINISH
   } seq_state_t;

endpackage

// File: rtl/pll_profile_rom.sv
// Combinational lookup of one profile table entry; indices past the table
// return an all-zero entry.
module pll_profile_rom
   import pll_profile_pkg::*;
(
   input  logic             profile,
   input  logic [IDX_W-1:0] index,
   output entry_t           entry
);

   always_comb begin
      entry = '0;
      if (32'(index) < PROFILE_LEN) begin
         entry = profile ? PROFILE_B[index] : PROFILE_A[index];
      end
   end

endmodule

// File: rtl/pll_profile_sequencer.sv
// Streams a stored PLL counter profile to the reconfiguration controller's
// management port, starts the update and waits for re-lock.
module pll_profile_sequencer
   import pll_profile_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned DROP_CYCLES    = 1024,
   parameter int unsigned NUM_ENTRIES    = 7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        profile_sel,
   input  logic        pll_locked,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   input  logic        mgmt_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        core_reset_n
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   seq_state_t       state;
   logic             profile;
   logic [IDX_W-1:0] idx;
   logic [31:0]      count;
   logic [IDX_W-1:0] rom_idx;
   entry_t           rom_entry;

   // The ROM is addressed with the entry to load once the current write completes
   assign rom_idx = (state == WR_TABLE) ? idx + IDX_W'(1) : '0;

   pll_profile_rom u_rom (
      .profile (profile),
      .index   (rom_idx),
      .entry   (rom_entry)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         profile        <= 1'b0;
         idx            <= '0;
         count          <= '0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
         mgmt_write     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         core_reset_n   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  profile        <= profile_sel;
                  error          <= 1'b0;
                  busy           <= 1'b1;
                  core_reset_n   <= 1'b0;
                  idx            <= '0;
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= ADDR_MODE;
                  mgmt_writedata <= '0;
                  state          <= WR_MODE;
               end else if (pll_locked && !error) begin
                  core_reset_n <= 1'b1;
               end
            end
            WR_MODE: begin
               if (!mgmt_waitrequest) begin
                  mgmt_address   <= rom_entry.addr;
                  mgmt_writedata <= rom_entry.data;
                  state          <= WR_TABLE;
               end
            end
            WR_TABLE: begin
               if (!mgmt_waitrequest) begin
                  if (idx == LAST_IDX) begin
                     mgmt_address   <= ADDR_START;
                     mgmt_writedata <= 32'd1;
                     state          <= WR_START;
                  end else begin
                     idx            <= idx + IDX_W'(1);
                     mgmt_address   <= rom_entry.addr;
                     mgmt_writedata <= rom_entry.data;
                  end
               end
            end
            WR_START: begin
               if (!mgmt_waitrequest) begin
                  mgmt_write <= 1'b0;
                  count      <= '0;
                  state      <= WAIT_DROP;
               end
            end
            WAIT_DROP: begin
               if (!pll_locked || count == DROP_CYCLES - 1) begin
                  count <= '0;
                  state <= WAIT_LOCK;
               end else begin
                  count <= count + 32'd1;
               end
            end
            WAIT_LOCK: begin
               if (pll_locked) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FINISH;
               end else if (count == TIMEOUT_CYCLES - 1) begin
                  error        <= 1'b1;
                  busy         <= 1'b0;
                  core_reset_n <= 1'b0;
                  state        <= IDLE;
               end else begin
                  count <= count + 32'd1;
               end
            end
            FINISH: begin
               core_reset_n <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
